// File: rtl/itype_pkg.sv
// Shared constants and decode-beat layout for the RV32 OP-IMM decode stage.
package itype_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_XORI = 3'b100;
  localparam logic [2:0] F3_SRXI = 3'b101;
  localparam logic [2:0] F3_ORI  = 3'b110;
  localparam logic [2:0] F3_ANDI = 3'b111;

  localparam int unsigned OP_ADDI = 0;
  localparam int unsigned OP_SLLI = 1;
  localparam int unsigned OP_XORI = 2;
  localparam int unsigned OP_SRLI = 3;
  localparam int unsigned OP_SRAI = 4;
  localparam int unsigned OP_ORI  = 5;
  localparam int unsigned OP_ANDI = 6;
  localparam int unsigned OP_W    = 7;

  localparam logic [6:0] FUNCT7_SRA = 7'b0100000;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic            rd_en;
    logic            wr_en;
    logic            illegal;
  } beat_ctl_t;

  localparam int unsigned BEAT_CTL_W = $bits(beat_ctl_t);

endpackage

// File: rtl/itype_decode_comb.sv
// Pure combinational OP-IMM decode of one instruction word into a beat.
module itype_decode_comb
  import itype_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic            is_op_imm,
  output beat_ctl_t       ctl,
  output logic [XLEN-1:0] imm
);

  localparam int unsigned SHW = $clog2(XLEN);
  // Bits above the shamt field that must match a shift funct pattern.
  localparam int unsigned FW  = 12 - SHW;

  logic [FW-1:0]  funct_hi;
  logic [FW-1:0]  sra_pat;
  logic [SHW-1:0] shamt;
  logic [2:0]     f3;
  logic           shift;

  assign is_op_imm = (instr[6:0] == OPC_OP_IMM);
  assign f3        = instr[14:12];
  assign funct_hi  = instr[31 -: FW];
  assign sra_pat   = FUNCT7_SRA[6 -: FW];
  assign shamt     = instr[20 +: SHW];

  always_comb begin
    ctl   = '0;
    shift = 1'b0;
    imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    case (f3)
      F3_ADDI: ctl.op[OP_ADDI] = 1'b1;
      F3_XORI: ctl.op[OP_XORI] = 1'b1;
      F3_ORI:  ctl.op[OP_ORI]  = 1'b1;
      F3_ANDI: ctl.op[OP_ANDI] = 1'b1;
      F3_SLLI: begin
        shift = 1'b1;
        if (funct_hi == '0) ctl.op[OP_SLLI] = 1'b1;
        else                ctl.illegal     = 1'b1;
      end
      F3_SRXI: begin
        shift = 1'b1;
        if (funct_hi == '0)          ctl.op[OP_SRLI] = 1'b1;
        else if (funct_hi == sra_pat) ctl.op[OP_SRAI] = 1'b1;
        else                          ctl.illegal     = 1'b1;
      end
      default: ctl.illegal = 1'b1;
    endcase
    if (shift) imm = {{(XLEN-SHW){1'b0}}, shamt};
    ctl.rs1   = instr[19:15];
    ctl.rd    = instr[11:7];
    ctl.rd_en = !ctl.illegal;
    ctl.wr_en = !ctl.illegal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/itype_decode_stage.sv
// OP-IMM decode stage: registered output beat with one skid entry and event counters.
module itype_decode_stage
  import itype_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_rd_en,
  output logic             out_wr_en,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] illegal_count
);

  logic            dec_is_op_imm;
  beat_ctl_t       dec_ctl;
  logic [XLEN-1:0] dec_imm;

  itype_decode_comb #(
    .XLEN (XLEN)
  ) u_decode (
    .instr     (in_instr),
    .is_op_imm (dec_is_op_imm),
    .ctl       (dec_ctl),
    .imm       (dec_imm)
  );

  beat_ctl_t       out_ctl_q, out_ctl_d, skid_ctl_q, skid_ctl_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;

  logic push, out_fire;

  assign in_ready = !skid_valid_q;
  assign out_fire = out_valid_q && out_ready;
  // Non-OP-IMM words are consumed but never produce a beat.
  assign push     = in_valid && in_ready && dec_is_op_imm;

  always_comb begin
    out_ctl_d    = out_ctl_q;
    out_imm_d    = out_imm_q;
    out_valid_d  = out_valid_q;
    skid_ctl_d   = skid_ctl_q;
    skid_imm_d   = skid_imm_q;
    skid_valid_d = skid_valid_q;
    dec_cnt_d    = dec_cnt_q;
    ill_cnt_d    = ill_cnt_q;

    if (out_fire || !out_valid_q) begin
      if (skid_valid_q) begin
        out_ctl_d    = skid_ctl_q;
        out_imm_d    = skid_imm_q;
        out_valid_d  = 1'b1;
        skid_valid_d = push;
        if (push) begin
          skid_ctl_d = dec_ctl;
          skid_imm_d = dec_imm;
        end
      end else if (push) begin
        out_ctl_d   = dec_ctl;
        out_imm_d   = dec_imm;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_ctl_d   = dec_ctl;
      skid_imm_d   = dec_imm;
      skid_valid_d = 1'b1;
    end

    if (out_fire) begin
      if (out_ctl_q.illegal) begin
        if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end else begin
        if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_ctl_q    <= '0;
      out_imm_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_ctl_q   <= '0;
      skid_imm_q   <= '0;
      skid_valid_q <= 1'b0;
      dec_cnt_q    <= '0;
      ill_cnt_q    <= '0;
    end else begin
      out_ctl_q    <= out_ctl_d;
      out_imm_q    <= out_imm_d;
      out_valid_q  <= out_valid_d;
      skid_ctl_q   <= skid_ctl_d;
      skid_imm_q   <= skid_imm_d;
      skid_valid_q <= skid_valid_d;
      dec_cnt_q    <= dec_cnt_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_op        = out_ctl_q.op;
  assign out_rs1       = out_ctl_q.rs1;
  assign out_rd        = out_ctl_q.rd;
  assign out_imm       = out_imm_q;
  assign out_rd_en     = out_ctl_q.rd_en;
  assign out_wr_en     = out_ctl_q.wr_en;
  assign out_illegal   = out_ctl_q.illegal;
  assign dec_count     = dec_cnt_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_itype_decode_stage.sv
// Directed bench for itype_decode_stage (XLEN=32, CNT_W=4 to reach saturation quickly).
module tb_itype_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_rd_en;
  logic        out_wr_en;
  logic        out_illegal;
  logic [3:0]  dec_count;
  logic [3:0]  illegal_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  itype_decode_stage #(
    .XLEN  (32),
    .CNT_W (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_rs1       (out_rs1),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_rd_en     (out_rd_en),
    .out_wr_en     (out_wr_en),
    .out_illegal   (out_illegal),
    .dec_count     (dec_count),
    .illegal_count (illegal_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rd, input logic [31:0] imm, input logic rd_en,
                          input logic wr_en, input logic ill);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".op"}, out_op, op);
    chk({tag, ".rs1"}, out_rs1, rs1);
    chk({tag, ".rd"}, out_rd, rd);
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".rd_en"}, out_rd_en, rd_en);
    chk({tag, ".wr_en"}, out_wr_en, wr_en);
    chk({tag, ".illegal"}, out_illegal, ill);
  endtask

  // Present one word for exactly one edge, then return at edge+1.
  task automatic send(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, rd, 7'b0010011};
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] expv;
  logic        held, fire, acc;
  logic [31:0] held_imm;
  logic [4:0]  held_rd;
  int          sent, got;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    #2;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.op", out_op, 7'd0);
    chk("rst.imm", out_imm, 32'd0);
    chk("rst.dec_count", dec_count, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst.in_ready", in_ready, 1'b1);

    // Decode patterns, one per cycle, consumer always ready.
    send(32'hFFF08293);
    chk_beat("addi_m1", 7'h01, 5'd1, 5'd5, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    chk("addi_m1.dec_count", dec_count, 4'd0);
    send(32'h40715193);
    chk_beat("srai", 7'h10, 5'd2, 5'd3, 32'd7, 1'b1, 1'b1, 1'b0);
    chk("srai.dec_count", dec_count, 4'd1);
    send(32'h20715193);
    chk_beat("bad_sra", 7'h00, 5'd2, 5'd3, 32'd7, 1'b0, 1'b0, 1'b1);
    send(32'h00000013);
    chk_beat("nop", 7'h01, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("nop.illegal_count", illegal_count, 4'd1);
    send(32'h00311093);
    chk_beat("slli", 7'h02, 5'd2, 5'd1, 32'd3, 1'b1, 1'b1, 1'b0);
    send(32'h02311093);
    chk_beat("bad_sll", 7'h00, 5'd2, 5'd1, 32'd3, 1'b0, 1'b0, 1'b1);
    send(32'h01F2D213);
    chk_beat("srli", 7'h08, 5'd5, 5'd4, 32'd31, 1'b1, 1'b1, 1'b0);
    send(32'h7FF47393);
    chk_beat("andi", 7'h40, 5'd8, 5'd7, 32'h0000_07FF, 1'b1, 1'b1, 1'b0);
    send(32'h0000A283);
    chk("lw.no_beat", out_valid, 1'b0);
    chk("lw.dec_count", dec_count, 4'd6);
    tick();
    chk("lw.dec_count_hold", dec_count, 4'd6);
    chk("lw.illegal_count", illegal_count, 4'd2);

    // Backpressure: two beats fill out reg + skid, third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = addi(5'd1, 12'd0);
    tick();
    chk("bp1.in_ready", in_ready, 1'b1);
    chk("bp1.rd", out_rd, 5'd1);
    in_instr = addi(5'd2, 12'd0);
    tick();
    chk("bp2.in_ready", in_ready, 1'b0);
    chk("bp2.rd", out_rd, 5'd1);
    in_instr = addi(5'd3, 12'd0);
    tick();
    chk("bp3.in_ready", in_ready, 1'b0);
    chk("bp3.rd_stable", out_rd, 5'd1);
    out_ready = 1'b1;
    tick();
    chk("bp4.rd", out_rd, 5'd2);
    chk("bp4.in_ready", in_ready, 1'b1);
    tick();
    chk("bp5.rd", out_rd, 5'd3);
    in_instr = addi(5'd4, 12'd0);
    tick();
    chk("bp6.rd", out_rd, 5'd4);
    in_valid = 1'b0;
    tick();
    chk("bp7.out_valid", out_valid, 1'b0);
    chk("bp7.dec_count", dec_count, 4'd10);

    // out_ready toggling every cycle with a continuous source of 6 ADDIs.
    held = 1'b0;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (held) begin
        chk("tog.stall_imm", out_imm, held_imm);
        chk("tog.stall_rd", out_rd, held_rd);
      end
      out_ready = cyc[0];
      in_valid  = (sent < 6);
      in_instr  = addi(5'(sent + 1), 12'(sent + 10));
      #1;
      fire = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (fire) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("tog.imm_order", out_imm, expv);
        got++;
      end
      held     = out_valid && !out_ready;
      held_imm = out_imm;
      held_rd  = out_rd;
      if (acc) begin
        exp_q.push_back(32'(sent + 10));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("tog.beats_received", got, 6);
    chk("tog.dec_count_sat", dec_count, 4'd15);

    // Reset with a full skid discards everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = addi(5'd9, 12'd1);
    tick();
    in_instr = addi(5'd10, 12'd2);
    tick();
    chk("mid.skid_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid.out_valid", out_valid, 1'b0);
    chk("mid.op", out_op, 7'd0);
    chk("mid.rd", out_rd, 5'd0);
    chk("mid.dec_count", dec_count, 4'd0);
    chk("mid.illegal_count", illegal_count, 4'd0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post.in_ready", in_ready, 1'b1);
    tick();
    chk("post.no_stale", out_valid, 1'b0);
    chk("post.dec_count", dec_count, 4'd0);

    // 17 legal beats with a 4-bit counter saturate at 15.
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_instr = addi(5'd6, 12'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat.dec_count", dec_count, 4'd15);
    chk("sat.illegal_count", illegal_count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
